// File: rtl/mario_pkg.sv
// Shared types and constants for Mario's per-frame logic: motion state,
// screen/sprite geometry and the default physics tuning.
package mario_pkg;

  typedef enum logic [1:0] {GROUND, RISE, FALL} motion_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;

  localparam int X_START_DEF    = 64;
  localparam int Y_FLOOR_DEF    = 400;
  localparam int X_MIN_DEF      = 0;
  localparam int X_MAX_DEF      = SCREEN_W - SPRITE_W;
  localparam int WALK_SPEED_DEF = 2;
  localparam int JUMP_VEL_DEF   = 12;
  localparam int GRAVITY_DEF    = 1;
  localparam int MAX_FALL_DEF   = 8;
  localparam int ANIM_DIV_DEF   = 4;

endpackage

// File: rtl/mario_motion_frame_tick_gen.sv
// Rising-edge detector on the frame strobe; emits a one-Clk tick per frame.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic frame_clk_q;

  // Clearing the history on reset makes a strobe held high across reset
  // release count as exactly one edge.
  always_ff @(posedge Clk) begin
    if (Reset) frame_clk_q <= 1'b0;
    else       frame_clk_q <= frame_clk;
  end

  assign tick = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/mario_motion.sv
// Per-frame player motion: clamped horizontal walk, jump/gravity state
// machine and walk animation, all advanced once per frame tick.
module mario_motion
  import mario_pkg::*;
#(
  parameter int X_START    = X_START_DEF,
  parameter int Y_FLOOR    = Y_FLOOR_DEF,
  parameter int X_MIN      = X_MIN_DEF,
  parameter int X_MAX      = X_MAX_DEF,
  parameter int WALK_SPEED = WALK_SPEED_DEF,
  parameter int JUMP_VEL   = JUMP_VEL_DEF,
  parameter int GRAVITY    = GRAVITY_DEF,
  parameter int MAX_FALL   = MAX_FALL_DEF,
  parameter int ANIM_DIV   = ANIM_DIV_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       w_on,
  input  logic       a_on,
  input  logic       d_on,
  output logic [9:0] mario_x,
  output logic [9:0] mario_y,
  output logic       facing_left,
  output logic       airborne,
  output logic       walking,
  output logic [1:0] anim_frame
);

  localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] YFLOOR_S = 11'(Y_FLOOR);
  localparam logic signed [5:0]  MAXF_S   = 6'(MAX_FALL);

  logic tick;

  frame_tick_gen u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  motion_state_t      state_q, state_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic signed [5:0]  x_vel_q, x_vel_d, y_vel_q, y_vel_d;
  logic               facing_q, facing_d;
  logic               armed_q, armed_d;
  logic [1:0]         anim_q, anim_d;
  logic [7:0]         div_q, div_d;

  logic signed [10:0] x_sum, y_sum;
  logic signed [5:0]  vel_inc;
  logic               walk_d;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x_vel_d  = '0;
    y_vel_d  = y_vel_q;
    facing_d = facing_q;
    armed_d  = armed_q;
    anim_d   = anim_q;
    div_d    = div_q;

    if (a_on && !d_on) begin
      x_vel_d  = -6'(WALK_SPEED);
      facing_d = 1'b1;
    end else if (d_on && !a_on) begin
      x_vel_d  = 6'(WALK_SPEED);
      facing_d = 1'b0;
    end

    // Signed 11-bit sum so walking past either edge saturates instead of wrapping.
    x_sum = $signed({1'b0, x_q}) + $signed({{5{x_vel_d[5]}}, x_vel_d});
    if (x_sum < XMIN_S)      x_d = X_MIN[9:0];
    else if (x_sum > XMAX_S) x_d = X_MAX[9:0];
    else                     x_d = x_sum[9:0];

    y_sum   = $signed({1'b0, y_q}) + $signed({{5{y_vel_q[5]}}, y_vel_q});
    vel_inc = y_vel_q + 6'(GRAVITY);

    case (state_q)
      GROUND: begin
        // Jump needs a fresh press: W must be seen released while grounded.
        if (w_on && armed_q) begin
          y_vel_d = -6'(JUMP_VEL);
          armed_d = 1'b0;
          state_d = RISE;
        end else if (!w_on) begin
          armed_d = 1'b1;
        end
      end
      RISE: begin
        if (y_sum < 11'sd0) begin
          y_d     = '0;
          y_vel_d = '0;
          state_d = FALL;
        end else begin
          y_d     = y_sum[9:0];
          y_vel_d = vel_inc;
          if (!vel_inc[5]) state_d = FALL;
        end
      end
      FALL: begin
        if (y_sum >= YFLOOR_S) begin
          y_d     = Y_FLOOR[9:0];
          y_vel_d = '0;
          state_d = GROUND;
        end else begin
          y_d     = y_sum[9:0];
          y_vel_d = (vel_inc > MAXF_S) ? MAXF_S : vel_inc;
        end
      end
      default: state_d = GROUND;
    endcase

    // Animation follows the post-tick walking status so the first step counts.
    walk_d = (x_vel_d != '0) && (state_d == GROUND);
    if (walk_d) begin
      if (div_q == 8'(ANIM_DIV - 1)) begin
        div_d  = '0;
        anim_d = anim_q + 2'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end else begin
      div_d  = '0;
      anim_d = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= GROUND;
      x_q      <= X_START[9:0];
      y_q      <= Y_FLOOR[9:0];
      x_vel_q  <= '0;
      y_vel_q  <= '0;
      facing_q <= 1'b0;
      armed_q  <= 1'b0;
      anim_q   <= '0;
      div_q    <= '0;
    end else if (tick) begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x_vel_q  <= x_vel_d;
      y_vel_q  <= y_vel_d;
      facing_q <= facing_d;
      armed_q  <= armed_d;
      anim_q   <= anim_d;
      div_q    <= div_d;
    end
  end

  assign mario_x     = x_q;
  assign mario_y     = y_q;
  assign facing_left = facing_q;
  assign anim_frame  = anim_q;
  assign airborne    = (state_q != GROUND);
  assign walking     = (x_vel_q != '0) && (state_q == GROUND);

endmodule

// File: tb/tb_mario_motion.sv
// Directed bench for mario_motion: walk, wall clamp, key conflict, jump
// profile, jump-while-walking and reset mid-jump.
module tb_mario_motion;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       w_on = 1'b0, a_on = 1'b0, d_on = 1'b0;
  logic [9:0] mario_x, mario_y;
  logic       facing_left, airborne, walking;
  logic [1:0] anim_frame;

  int n_chk  = 0;
  int n_fail = 0;

  mario_motion dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .w_on        (w_on),
    .a_on        (a_on),
    .d_on        (d_on),
    .mario_x     (mario_x),
    .mario_y     (mario_y),
    .facing_left (facing_left),
    .airborne    (airborne),
    .walking     (walking),
    .anim_frame  (anim_frame)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    w_on = 0; a_on = 0; d_on = 0; frame_clk = 0;
    @(negedge Clk); Reset = 1;
    @(negedge Clk); @(negedge Clk); Reset = 0;
  endtask

  // One frame: strobe high for one Clk edge, then low for one.
  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge Clk); frame_clk = 1;
      @(negedge Clk); frame_clk = 0;
    end
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_x", 32'(mario_x), 64);
    chk("rst_y", 32'(mario_y), 400);
    chk("rst_face", 32'(facing_left), 0);
    chk("rst_air", 32'(airborne), 0);
    chk("rst_walk", 32'(walking), 0);
    chk("rst_anim", 32'(anim_frame), 0);

    // Walk right
    d_on = 1;
    tick_n(1);
    chk("r1_x", 32'(mario_x), 66);
    tick_n(3);
    chk("r4_anim", 32'(anim_frame), 1);
    tick_n(4);
    chk("r8_x", 32'(mario_x), 80);
    chk("r8_anim", 32'(anim_frame), 2);
    tick_n(2);
    chk("r10_x", 32'(mario_x), 84);
    chk("r10_face", 32'(facing_left), 0);
    chk("r10_walk", 32'(walking), 1);

    // Walk left into the wall
    do_reset();
    a_on = 1;
    tick_n(31);
    chk("l31_x", 32'(mario_x), 2);
    tick_n(1);
    chk("l32_x", 32'(mario_x), 0);
    chk("l32_face", 32'(facing_left), 1);
    tick_n(8);
    chk("l40_x", 32'(mario_x), 0);

    // Both keys held
    do_reset();
    a_on = 1; d_on = 1;
    tick_n(5);
    chk("ad_x", 32'(mario_x), 64);
    chk("ad_face", 32'(facing_left), 0);
    chk("ad_walk", 32'(walking), 0);
    chk("ad_anim", 32'(anim_frame), 0);
    d_on = 0;
    tick_n(1);
    chk("ad_l_x", 32'(mario_x), 62);
    d_on = 1;
    tick_n(3);
    chk("ad2_x", 32'(mario_x), 62);
    chk("ad2_face", 32'(facing_left), 1);
    chk("ad2_walk", 32'(walking), 0);
    chk("ad2_anim", 32'(anim_frame), 0);

    // Jump-only profile
    do_reset();
    tick_n(1);
    w_on = 1;
    tick_n(1);
    chk("j0_y", 32'(mario_y), 400);
    chk("j0_air", 32'(airborne), 1);
    tick_n(12);
    chk("j12_y", 32'(mario_y), 322);
    tick_n(1);
    chk("f1_y", 32'(mario_y), 322);
    tick_n(13);
    chk("f14_y", 32'(mario_y), 398);
    chk("f14_air", 32'(airborne), 1);
    tick_n(1);
    chk("land_y", 32'(mario_y), 400);
    chk("land_air", 32'(airborne), 0);
    tick_n(3);
    chk("hold_w_air", 32'(airborne), 0);
    chk("hold_w_y", 32'(mario_y), 400);
    w_on = 0;
    tick_n(1);
    chk("rearm_air", 32'(airborne), 0);
    w_on = 1;
    tick_n(1);
    chk("rejump_air", 32'(airborne), 1);
    tick_n(5);
    chk("mid_y", 32'(mario_y), 350);

    // Reset mid-RISE with strobe and W held across release
    Reset = 1; frame_clk = 1;
    @(negedge Clk);
    chk("mr_y", 32'(mario_y), 400);
    chk("mr_x", 32'(mario_x), 64);
    chk("mr_air", 32'(airborne), 0);
    Reset = 0; d_on = 1;
    repeat (5) @(negedge Clk);
    chk("mr_onetick_x", 32'(mario_x), 66);
    chk("mr_noarm_air", 32'(airborne), 0);
    frame_clk = 0;

    // Jump while walking right
    do_reset();
    d_on = 1;
    tick_n(1);
    chk("dj_arm_x", 32'(mario_x), 66);
    w_on = 1;
    tick_n(1);
    chk("dj0_x", 32'(mario_x), 68);
    chk("dj0_walk", 32'(walking), 0);
    chk("dj0_air", 32'(airborne), 1);
    tick_n(12);
    chk("dj12_x", 32'(mario_x), 92);
    chk("dj12_y", 32'(mario_y), 322);
    tick_n(15);
    chk("dj_land_x", 32'(mario_x), 122);
    chk("dj_land_y", 32'(mario_y), 400);
    chk("dj_land_air", 32'(airborne), 0);
    chk("dj_land_walk", 32'(walking), 1);
    chk("dj_land_anim", 32'(anim_frame), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mario_motion.md
Name: mario_motion

Overview:
- Per-frame player motion controller for Mario.
- Consumes the decoded key flags (w_on = jump, a_on = left, d_on = right) from the keyboard decode stage.
- Integrates horizontal walk and vertical jump/gravity once per video frame.
- Outputs the sprite's top-left position, facing and animation state to the sprite/draw logic.

Parameters:
- X_START, 64: X coordinate after reset.
- Y_FLOOR, 400: Y coordinate of the top-left corner when standing on the ground.
- X_MIN, 0: leftmost allowed X.
- X_MAX, 608: rightmost allowed X.
- WALK_SPEED, 2: horizontal pixels per frame.
- JUMP_VEL, 12: magnitude of the initial upward velocity, in pixels per frame.
- GRAVITY, 1: velocity increment per frame.
- MAX_FALL, 8: downward velocity cap.
- ANIM_DIV, 4: frame ticks per walk-animation step.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  vsync-derived frame strobe, level signal, synchronous to Clk
- w_on  in  1  jump key held
- a_on  in  1  left key held
- d_on  in  1  right key held
- mario_x  out  10  sprite X, unsigned
- mario_y  out  10  sprite Y, unsigned
- facing_left  out  1  1 = sprite mirrored
- airborne  out  1  1 when the state is not GROUND
- walking  out  1  1 when x_vel != 0 and the state is GROUND
- anim_frame  out  2  walk animation index

Behaviour:
- One clock domain, Clk.
- Reset is synchronous and active-high; it overrides everything, including mid-jump.
- Reset values:
  - mario_x = X_START, mario_y = Y_FLOOR
  - x_vel = 0, y_vel = 0, state = GROUND
  - facing_left = 0, anim_frame = 0, jump_armed = 0
  - frame_clk_d = 0, so the first high sample of frame_clk after reset counts as an edge.
- Tick:
  - frame_clk_d is a one-cycle register of frame_clk.
  - tick = frame_clk & ~frame_clk_d.
  - All motion, state and animation registers update only on a Clk edge where tick = 1; outputs are stable between ticks.
  - Latency: outputs change one Clk after the first sampled high cycle of frame_clk.
- Horizontal:
  - a_on & ~d_on: x_vel = -WALK_SPEED, facing_left <= 1.
  - d_on & ~a_on: x_vel = +WALK_SPEED, facing_left <= 0.
  - Both keys or neither: x_vel = 0, facing_left unchanged.
  - Horizontal motion applies in every state.
  - Compute X + x_vel in 11-bit signed and clamp to [X_MIN, X_MAX]; no wrap-around.
- Vertical: 11-bit signed Y arithmetic, 6-bit signed y_vel. States GROUND, RISE, FALL.
  - GROUND, w_on & jump_armed: y_vel <= -JUMP_VEL, jump_armed <= 0, go to RISE. Y unchanged this tick.
  - GROUND, ~w_on: jump_armed <= 1. W must be released between jumps; holding W through reset or landing never re-jumps.
  - RISE: Y <= Y + y_vel, y_vel <= y_vel + GRAVITY.
    - If the new y_vel >= 0, go to FALL.
    - If Y + y_vel < 0: Y <= 0, y_vel <= 0, go to FALL (ceiling).
  - FALL: y_vel <= min(y_vel + GRAVITY, MAX_FALL).
    - If Y + y_vel >= Y_FLOOR: Y <= Y_FLOOR, y_vel <= 0, go to GROUND. This lands exactly on the floor; no overshoot.
    - Otherwise Y <= Y + y_vel.
  - Key inputs during RISE/FALL affect only horizontal motion.
- Animation:
  - While walking, a divider counts ticks; every ANIM_DIV ticks, anim_frame increments mod 4.
  - When not walking, the divider and anim_frame are held at 0.
- airborne and walking are combinational from the registered state and x_vel.

Decomposition:
- Package mario_pkg holds:
  - typedef enum logic [1:0] {GROUND, RISE, FALL} motion_state_t
  - screen constants (640x480, sprite 32x32)
  - default physics constants, shared with the sprite and collision logic.
- One natural sub-module: frame_tick_gen, the frame_clk rising-edge detector producing a 1-cycle tick. It is reused by the other per-frame blocks.

Test Plan:
- Reset, then d_on held 10 ticks -> mario_x = 84, facing_left = 0, walking = 1; anim_frame = 2 after 8 ticks.
- Reset, then a_on held 40 ticks -> mario_x saturates at 0 after 32 ticks and stays 0, facing_left = 1.
- a_on and d_on held together from X = 64 -> mario_x stays 64, facing_left unchanged, walking = 0, anim_frame = 0.
- One tick with w_on = 0, then w_on held -> the next tick enters RISE; after 12 more ticks mario_y = 322, state FALL. Mario lands with mario_y = 400 exactly and airborne drops to 0. W still held at landing -> no second jump until one tick with w_on = 0.
- d_on plus a jump from X = 64 -> x advances 2 per tick throughout the air phase, and Y follows the same profile as the jump-only scenario.
- Reset asserted mid-RISE (mario_y = 350) -> on the next Clk: mario_y = 400, mario_x = 64, state GROUND, jump_armed = 0. frame_clk held high across reset release -> exactly one tick is generated.
